imm_gen_stage: RTL and testbench

Parametrised, registered immediate generator for the IDU. It extracts and sign-/zero-extends the RISC-V immediate for a given extension mode to XLEN bits and precomputes the PC-relative target `pc + imm`. It sits between decode and the EXU issue path behind a valid/ready handshake, with a 2-entry skid buffer so that `in_ready` is a pure register output. It supersedes the purely combinational immediate mux by adding XLEN generality, the Z/shamt modes, an illegal-mode flag and pipelining.

---
 rtl/idu_pkg.sv | 17 +
 rtl/imm_extract.sv | 40 ++++
 rtl/imm_gen_stage.sv | 119 +++++++++++
 tb/tb_imm_gen_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// Shared IDU constants: immediate extension modes and skid-buffer state encoding.
package idu_pkg;

    localparam logic [2:0] EXT_I   = 3'b000;
    localparam logic [2:0] EXT_U   = 3'b001;
    localparam logic [2:0] EXT_S   = 3'b010;
    localparam logic [2:0] EXT_B   = 3'b011;
    localparam logic [2:0] EXT_J   = 3'b100;
    localparam logic [2:0] EXT_Z   = 3'b101;
    localparam logic [2:0] EXT_SH  = 3'b110;
    localparam logic [2:0] EXT_ILL = 3'b111;

    localparam logic [1:0] SKID_EMPTY = 2'd0;
    localparam logic [1:0] SKID_ONE   = 2'd1;
    localparam logic [1:0] SKID_TWO   = 2'd2;

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate extraction and extension to XLEN bits.
module imm_extract #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      ext_opt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    import idu_pkg::*;

    // Every mode is assembled at 64 bits and narrowed, so XLEN=32 and 64 share one table.
    logic [63:0] w_full;
    logic        w_unused;

    // Mode-driven field selection with sign or zero extension.
    always_comb begin
        w_full  = '0;
        illegal = 1'b0;
        case (ext_opt)
            EXT_I:  w_full = {{52{inst[31]}}, inst[31:20]};
            EXT_U:  w_full = {{32{inst[31]}}, inst[31:12], 12'b0};
            EXT_S:  w_full = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            EXT_B:  w_full = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            EXT_J:  w_full = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            EXT_Z:  w_full = {59'b0, inst[19:15]};
            EXT_SH: begin
                if (XLEN == 64) w_full = {58'b0, inst[25:20]};
                else            w_full = {59'b0, inst[24:20]};
            end
            EXT_ILL: illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    assign imm      = w_full[XLEN-1:0];
    // Opcode bits and, for XLEN=32, the upper half never reach the output.
    assign w_unused = ^{inst[6:0], w_full};

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator: extract/extend, precompute pc+imm, hand off via skid buffer.
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_ext_opt,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);
    import idu_pkg::*;

    localparam int PW = 3 * XLEN + 1;

    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;
    logic [PW-1:0]   w_in_pay;
    logic [PW-1:0]   w_out_pay;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst    (in_inst),
        .ext_opt (in_ext_opt),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    // Carry-out is dropped: the target wraps modulo 2^XLEN.
    assign w_target = in_pc + w_imm;
    assign w_in_pay = {w_illegal, w_target, in_pc, w_imm};
    assign {out_illegal, out_target, out_pc, out_imm} = w_out_pay;

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]    r_state;
            logic          r_in_ready;
            logic [PW-1:0] r_head;
            logic [PW-1:0] r_skid;
            logic          w_acc;
            logic          w_drn;

            assign w_acc     = in_valid && r_in_ready;
            assign w_drn     = (r_state != SKID_EMPTY) && out_ready;
            assign in_ready  = r_in_ready;
            assign out_valid = (r_state != SKID_EMPTY);
            assign w_out_pay = r_head;

            // Two-entry skid: head drives the outputs, skid absorbs the word that
            // arrives in the cycle the registered in_ready could not yet drop.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_state    <= SKID_EMPTY;
                    r_in_ready <= 1'b0;
                    r_head     <= '0;
                    r_skid     <= '0;
                end else begin
                    r_in_ready <= 1'b1;
                    case (r_state)
                        SKID_EMPTY: begin
                            if (w_acc) begin
                                r_head  <= w_in_pay;
                                r_state <= SKID_ONE;
                            end
                        end
                        SKID_ONE: begin
                            if (w_acc && w_drn) begin
                                r_head <= w_in_pay;
                            end else if (w_acc) begin
                                r_skid     <= w_in_pay;
                                r_state    <= SKID_TWO;
                                r_in_ready <= 1'b0;
                            end else if (w_drn) begin
                                r_state <= SKID_EMPTY;
                            end
                        end
                        SKID_TWO: begin
                            r_in_ready <= w_drn;
                            if (w_drn) begin
                                r_head  <= r_skid;
                                r_state <= SKID_ONE;
                            end
                        end
                        default: r_state <= SKID_EMPTY;
                    endcase
                end
            end
        end else begin : g_single
            logic          r_valid;
            logic [PW-1:0] r_head;

            assign in_ready  = !reset && (!r_valid || out_ready);
            assign out_valid = r_valid;
            assign w_out_pay = r_head;

            // Single output register; refilled in the same cycle it drains.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_head  <= '0;
                end else if (in_valid && in_ready) begin
                    r_valid <= 1'b1;
                    r_head  <= w_in_pay;
                end else if (r_valid && out_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: XLEN=32/SKID=1 and XLEN=64/SKID=0 instances against a reference model.
module tb_imm_gen_stage;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] pc;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic rnd_on;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_inst;
    logic [2:0]  a_in_ext;
    logic [31:0] a_in_pc, a_out_imm, a_out_pc, a_out_target;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_inst;
    logic [2:0]  b_in_ext;
    logic [63:0] b_in_pc, b_out_imm, b_out_pc, b_out_target;

    exp_t qa[$];
    exp_t qb[$];

    imm_gen_stage #(.XLEN(32), .SKID(1)) dut_a (
        .clock(clk), .reset(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst),
        .in_ext_opt(a_in_ext), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_pc(a_out_pc), .out_target(a_out_target), .out_illegal(a_out_illegal)
    );

    imm_gen_stage #(.XLEN(64), .SKID(0)) dut_b (
        .clock(clk), .reset(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst),
        .in_ext_opt(b_in_ext), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_pc(b_out_pc), .out_target(b_out_target), .out_illegal(b_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the immediate as a signed integer value, then reduced modulo 2^xlen.
    function automatic exp_t model(input logic [31:0] inst, input logic [2:0] mode,
                                   input logic [63:0] pc, input int xlen);
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        logic signed [31:0] s32;
        longint             v;
        logic [63:0]        mask;
        exp_t               e;
        mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        e.ill = 1'b0;
        case (mode)
            3'd0: begin s12 = inst[31:20]; v = longint'(s12); end
            3'd1: begin s32 = {inst[31:12], 12'h000}; v = longint'(s32); end
            3'd2: begin s12 = {inst[31:25], inst[11:7]}; v = longint'(s12); end
            3'd3: begin s13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; v = longint'(s13); end
            3'd4: begin s21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; v = longint'(s21); end
            3'd5: v = {59'b0, inst[19:15]};
            3'd6: begin
                if (xlen == 32) v = {59'b0, inst[24:20]};
                else            v = {58'b0, inst[25:20]};
            end
            default: begin v = 0; e.ill = 1'b1; end
        endcase
        e.imm = 64'(v) & mask;
        e.pc  = pc & mask;
        e.tgt = (pc + e.imm) & mask;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pop on every drain, push on every accept; reset discards held entries.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("a_spurious_out", 64'(a_out_valid), 64'd0);
                else begin
                    e = qa.pop_front();
                    chk("a_imm", 64'(a_out_imm), e.imm);
                    chk("a_pc", 64'(a_out_pc), e.pc);
                    chk("a_target", 64'(a_out_target), e.tgt);
                    chk("a_illegal", 64'(a_out_illegal), 64'(e.ill));
                end
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) chk("b_spurious_out", 64'(b_out_valid), 64'd0);
                else begin
                    e = qb.pop_front();
                    chk("b_imm", b_out_imm, e.imm);
                    chk("b_pc", b_out_pc, e.pc);
                    chk("b_target", b_out_target, e.tgt);
                    chk("b_illegal", 64'(b_out_illegal), 64'(e.ill));
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back(model(a_in_inst, a_in_ext, 64'(a_in_pc), 32));
            if (b_in_valid && b_in_ready) qb.push_back(model(b_in_inst, b_in_ext, b_in_pc, 64));
        end
    end

    // Present a word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_a(input logic [31:0] inst, input logic [2:0] m, input logic [31:0] pc);
        int n;
        n = 0;
        a_in_valid = 1'b1; a_in_inst = inst; a_in_ext = m; a_in_pc = pc;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL a_accept_timeout: in_ready stayed %b, required 1", a_in_ready);
            a_in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            a_in_valid = 1'b0;
        end
    endtask

    task automatic send_b(input logic [31:0] inst, input logic [2:0] m, input logic [63:0] pc);
        int n;
        n = 0;
        b_in_valid = 1'b1; b_in_inst = inst; b_in_ext = m; b_in_pc = pc;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL b_accept_timeout: in_ready stayed %b, required 1", b_in_ready);
            b_in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            b_in_valid = 1'b0;
        end
    endtask

    task automatic direct_a(input string nm, input logic [31:0] inst, input logic [2:0] m,
                            input logic [31:0] pc, input logic [31:0] ei, input logic [31:0] et,
                            input logic eill);
        send_a(inst, m, pc);
        chk({nm, "_valid"}, 64'(a_out_valid), 64'd1);
        chk({nm, "_imm"}, 64'(a_out_imm), 64'(ei));
        chk({nm, "_target"}, 64'(a_out_target), 64'(et));
        chk({nm, "_illegal"}, 64'(a_out_illegal), 64'(eill));
    endtask

    task automatic direct_b(input string nm, input logic [31:0] inst, input logic [2:0] m,
                            input logic [63:0] pc, input logic [63:0] ei, input logic [63:0] et,
                            input logic eill);
        send_b(inst, m, pc);
        chk({nm, "_valid"}, 64'(b_out_valid), 64'd1);
        chk({nm, "_imm"}, b_out_imm, ei);
        chk({nm, "_target"}, b_out_target, et);
        chk({nm, "_illegal"}, 64'(b_out_illegal), 64'(eill));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        n_cmp = 0; n_err = 0; rnd_on = 1'b0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_inst = '0; a_in_ext = '0; a_in_pc = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_inst = '0; b_in_ext = '0; b_in_pc = '0; b_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_in_ready_low", 64'(a_in_ready), 64'd0);
        chk("rst_b_in_ready_low", 64'(b_in_ready), 64'd0);
        rst = 1'b0;
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_outputs", {a_out_imm, a_out_target}, 64'd0);
        chk("rst_a_pc_ill", {a_out_pc, 31'd0, a_out_illegal}, 64'd0);
        chk("rst_b_valid", 64'(b_out_valid), 64'd0);
        chk("rst_b_imm", b_out_imm, 64'd0);
        @(posedge clk); #1;
        chk("rst_a_in_ready_up", 64'(a_in_ready), 64'd1);
        chk("rst_b_in_ready_up", 64'(b_in_ready), 64'd1);

        // Directed vectors, downstream always ready.
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        direct_a("a_I_neg1", 32'hFFF00093, 3'b000, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0FFF, 1'b0);
        direct_a("a_U", 32'h12345037, 3'b001, 32'h0000_0000, 32'h1234_5000, 32'h1234_5000, 1'b0);
        direct_a("a_J", 32'h008000EF, 3'b100, 32'h8000_0000, 32'h0000_0008, 32'h8000_0008, 1'b0);
        direct_a("a_B_m2052", 32'hFE000E63, 3'b011, 32'h8000_0010, 32'hFFFF_F7FC, 32'h7FFF_F80C, 1'b0);
        direct_a("a_B_m2052_pc0", 32'hFE000E63, 3'b011, 32'h0000_0000, 32'hFFFF_F7FC, 32'hFFFF_F7FC, 1'b0);
        direct_a("a_B_m4", 32'hFE000EE3, 3'b011, 32'h8000_0010, 32'hFFFF_FFFC, 32'h8000_000C, 1'b0);
        direct_a("a_B_m4_pc0", 32'hFE000EE3, 3'b011, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        direct_a("a_SH32", 32'h03F01013, 3'b110, 32'h0000_0004, 32'h0000_001F, 32'h0000_0023, 1'b0);
        direct_b("b_U_neg", 32'h80000037, 3'b001, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        direct_b("b_SH64", 32'h03F01013, 3'b110, 64'h10, 64'd63, 64'h4F, 1'b0);
        direct_b("b_illegal", 32'hFFFFFFFF, 3'b111, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1);
        direct_b("b_Z", 32'h000F8073, 3'b101, 64'h8, 64'd31, 64'd39, 1'b0);
        repeat (2) @(posedge clk); #1;

        // Backpressure on the skid instance.
        a_out_ready = 1'b0;
        send_a(32'h00100093, 3'b000, 32'h100);
        chk("bp_in_ready_after_1", 64'(a_in_ready), 64'd1);
        send_a(32'h00200093, 3'b000, 32'h104);
        chk("bp_in_ready_after_2", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b1; a_in_inst = 32'h00300093; a_in_ext = 3'b000; a_in_pc = 32'h108;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_held_in_ready", 64'(a_in_ready), 64'd0);
            chk("bp_head_stable", 64'(a_out_imm), 64'd1);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        cnt = 0;
        fork
            begin
                send_a(32'h00300093, 3'b000, 32'h108);
                send_a(32'h00400093, 3'b000, 32'h10C);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (a_out_valid) cnt++;
                end
            end
        join
        chk("bp_no_gap_count", 64'(cnt), 64'd4);
        repeat (3) @(posedge clk); #1;
        chk("bp_drained", 64'(qa.size()), 64'd0);

        // Reset while two entries are held.
        a_out_ready = 1'b0;
        send_a(32'h00500093, 3'b000, 32'h200);
        send_a(32'h00600093, 3'b000, 32'h204);
        chk("mr_full", 64'(a_in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_valid", 64'(a_out_valid), 64'd0);
        chk("mr_imm_tgt", {a_out_imm, a_out_target}, 64'd0);
        chk("mr_pc_ill", {a_out_pc, 31'd0, a_out_illegal}, 64'd0);
        @(posedge clk); #1;
        chk("mr_in_ready", 64'(a_in_ready), 64'd1);
        chk("mr_valid_later", 64'(a_out_valid), 64'd0);
        a_out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("mr_no_ghost", 64'(a_out_valid), 64'd0);

        // Randomised traffic with random downstream stalls.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    a_out_ready = ($urandom_range(0, 2) != 0);
                    b_out_ready = ($urandom_range(0, 2) != 0);
                end
            end
            begin
                fork
                    begin
                        for (int i = 0; i < 200; i++) begin
                            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                            send_a($urandom, 3'($urandom_range(0, 7)), $urandom);
                        end
                    end
                    begin
                        for (int i = 0; i < 200; i++) begin
                            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                            send_b($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
                        end
                    end
                join
                rnd_on = 1'b0;
            end
        join
        @(posedge clk); #1;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("end_a_queue_empty", 64'(qa.size()), 64'd0);
        chk("end_b_queue_empty", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
